hash_accumulator: RTL and testbench

HASH_ACCUMULATOR -- requirements
Module: hash_accumulator

---
 rtl/hash_accumulator.sv | 137 +++++++++++++
 tb/tb_hash_accumulator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_accumulator.sv
// rtl/hash_accumulator.sv - collects HASH_LENGTH words into a hash vector, optionally adding a previous hash
//
// Ports:
//   clock                 rising-edge clock for all state
//   reset                 synchronous, active-high reset (wins over every other input)
//   start                 begin a new accumulation when in IDLE or DONE
//   add_mode              sampled with start: 1 = add to prev_hash_vector, 0 = plain load
//   word_valid            word_index / word_data are offered this cycle
//   word_index            slot the offered word is meant for
//   word_data             offered word
//   prev_hash_vector      previous hash, word i at [i*WORD_WIDTH +: WORD_WIDTH]
//   word_ready            high only while collecting
//   hash_vector           assembled hash, same packing as prev_hash_vector
//   hash_vector_complete  level, high only in DONE
//   order_error           sticky out-of-order flag, cleared by start or reset
//
// Build option:
//   HASH_ACCUMULATOR_ORDER_CHECK_EN  when defined, words whose word_index does not
//                                    match the expected slot are dropped and flagged;
//                                    otherwise word_index is ignored and order_error is 0.

module hash_accumulator #(
    parameter int HASH_LENGTH = 8,
    parameter int WORD_WIDTH  = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              add_mode,
    input  logic                              word_valid,
    input  logic [$clog2(HASH_LENGTH)-1:0]    word_index,
    input  logic [WORD_WIDTH-1:0]             word_data,
    input  logic [HASH_LENGTH*WORD_WIDTH-1:0] prev_hash_vector,
    output logic                              word_ready,
    output logic [HASH_LENGTH*WORD_WIDTH-1:0] hash_vector,
    output logic                              hash_vector_complete,
    output logic                              order_error
);

    localparam int                IW        = $clog2(HASH_LENGTH);
    localparam logic [IW-1:0]     LAST_SLOT = IW'(HASH_LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t                state;
    logic [IW-1:0]         counter;
    logic                  add_mode_q;

    logic                  accept;
    logic                  index_ok;
    logic [WORD_WIDTH-1:0] prev_word;
    logic [WORD_WIDTH-1:0] new_word;

    // word_ready is a registered copy of "state == COLLECT", so the handshake
    // never depends combinationally on the inputs.
    assign accept = word_valid && word_ready;

    // The previous hash is read at the acceptance cycle for the slot being written.
    always_comb begin
        prev_word = prev_hash_vector[int'(counter)*WORD_WIDTH +: WORD_WIDTH];
        new_word  = add_mode_q ? (word_data + prev_word) : word_data;
    end

`ifdef HASH_ACCUMULATOR_ORDER_CHECK_EN
    logic order_error_q;

    assign index_ok    = (word_index == counter);
    assign order_error = order_error_q;
`else
    logic unused_word_index;

    assign index_ok          = 1'b1;
    assign unused_word_index = ^word_index;
    assign order_error       = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= IDLE;
            counter              <= '0;
            add_mode_q           <= 1'b0;
            hash_vector          <= '0;
            word_ready           <= 1'b0;
            hash_vector_complete <= 1'b0;
`ifdef HASH_ACCUMULATOR_ORDER_CHECK_EN
            order_error_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    // word_valid is ignored here; only start moves the FSM.
                    if (start) begin
                        state                <= COLLECT;
                        counter              <= '0;
                        add_mode_q           <= add_mode;
                        hash_vector          <= '0;
                        word_ready           <= 1'b1;
                        hash_vector_complete <= 1'b0;
`ifdef HASH_ACCUMULATOR_ORDER_CHECK_EN
                        order_error_q        <= 1'b0;
`endif
                    end
                end

                COLLECT: begin
                    // start is deliberately not looked at while collecting.
                    if (accept) begin
                        if (index_ok) begin
                            hash_vector[int'(counter)*WORD_WIDTH +: WORD_WIDTH] <= new_word;
                            counter <= counter + 1'b1;
                            if (counter == LAST_SLOT) begin
                                state                <= DONE;
                                word_ready           <= 1'b0;
                                hash_vector_complete <= 1'b1;
                            end
                        end else begin
`ifdef HASH_ACCUMULATOR_ORDER_CHECK_EN
                            // Dropped word: no write, counter holds, ready stays high.
                            order_error_q <= 1'b1;
`endif
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    word_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_accumulator.sv
// tb/tb_hash_accumulator.sv - directed self-checking bench for hash_accumulator

module tb_hash_accumulator;

    localparam int HL = 8;
    localparam int WW = 32;
    localparam int VW = HL * WW;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          add_mode;
    logic          word_valid;
    logic [2:0]    word_index;
    logic [WW-1:0] word_data;
    logic [VW-1:0] prev_hash_vector;
    logic          word_ready;
    logic [VW-1:0] hash_vector;
    logic          hash_vector_complete;
    logic          order_error;

    hash_accumulator #(
        .HASH_LENGTH(HL),
        .WORD_WIDTH (WW)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .start               (start),
        .add_mode            (add_mode),
        .word_valid          (word_valid),
        .word_index          (word_index),
        .word_data           (word_data),
        .prev_hash_vector    (prev_hash_vector),
        .word_ready          (word_ready),
        .hash_vector         (hash_vector),
        .hash_vector_complete(hash_vector_complete),
        .order_error         (order_error)
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            errors = 0;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] exp_v;
    logic [VW-1:0] pv;
    logic [WW-1:0] d[HL];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic do_start(input logic mode);
        start    = 1'b1;
        add_mode = mode;
        tick();
        start    = 1'b0;
        add_mode = 1'b0;
    endtask

    task automatic offer(input logic [2:0] idx, input logic [WW-1:0] data, input logic [VW-1:0] prev);
        word_valid       = 1'b1;
        word_index       = idx;
        word_data        = data;
        prev_hash_vector = prev;
        tick();
        word_valid       = 1'b0;
    endtask

    // Bounded wait for completion, then pop the scoreboard and compare.
    task automatic wait_complete(input string tag);
        int n = 0;
        while (!hash_vector_complete && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_complete"}, VW'(hash_vector_complete), VW'(1'b1));
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, VW'(0), VW'(1));
        end else begin
            exp_v = exp_q.pop_front();
            check(tag, hash_vector, exp_v);
        end
    endtask

    initial begin
        reset            = 1'b1;
        start            = 1'b0;
        add_mode         = 1'b0;
        word_valid       = 1'b0;
        word_index       = '0;
        word_data        = '0;
        prev_hash_vector = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_ready",    VW'(word_ready),           VW'(1'b0));
        check("rst_hash",     hash_vector,               '0);
        check("rst_complete", VW'(hash_vector_complete), VW'(1'b0));
        check("rst_order",    VW'(order_error),          VW'(1'b0));

        // Plain load of the SHA-256 initial values, back to back.
        d = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        exp_v = '0;
        for (int i = 0; i < HL; i++) exp_v[i*WW +: WW] = d[i];
        exp_q.push_back(exp_v);
        do_start(1'b0);
        check("load_ready", VW'(word_ready), VW'(1'b1));
        for (int i = 0; i < HL - 1; i++) offer(3'(i), d[i], '1);
        check("load_pre_last_complete", VW'(hash_vector_complete), VW'(1'b0));
        offer(3'd7, d[7], '1);
        check("load_complete_latency", VW'(hash_vector_complete), VW'(1'b1));
        wait_complete("load");
        check("load_word0", VW'(hash_vector[31:0]),    VW'(32'h6a09e667));
        check("load_word7", VW'(hash_vector[255:224]), VW'(32'h5be0cd19));
        check("done_ready", VW'(word_ready),           VW'(1'b0));

        // DONE holds; word_valid there is ignored.
        offer(3'd0, 32'hdeadbeef, '0);
        offer(3'd1, 32'hcafef00d, '0);
        tick();
        check("done_hold_hash",     hash_vector,               exp_v);
        check("done_hold_complete", VW'(hash_vector_complete), VW'(1'b1));

        // Restart from DONE in add mode; carry out of slot 0 is discarded.
        pv    = '0;
        pv[31:0] = 32'hFFFFFFFF;
        exp_v = '0;
        for (int i = 0; i < HL; i++) exp_v[i*WW +: WW] = 32'h00000001;
        exp_q.push_back(exp_v);
        do_start(1'b1);
        check("restart_complete", VW'(hash_vector_complete), VW'(1'b0));
        check("restart_hash",     hash_vector,               '0);
        check("restart_ready",    VW'(word_ready),           VW'(1'b1));
        offer(3'd0, 32'h00000002, pv);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("collect_start_ignored_hash",  hash_vector,      VW'(32'h00000001));
        check("collect_start_ignored_ready", VW'(word_ready),  VW'(1'b1));
        for (int i = 1; i < HL; i++) offer(3'(i), 32'h00000001, pv);
        wait_complete("add_wrap");

        // Add mode with prev_hash_vector changing every cycle.
        exp_v = '0;
        for (int i = 0; i < HL; i++) d[i] = $urandom;
        do_start(1'b1);
        for (int i = 0; i < HL; i++) begin
            pv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            exp_v[i*WW +: WW] = d[i] + pv[i*WW +: WW];
            if (i == HL - 1) exp_q.push_back(exp_v);
            offer(3'(i), d[i], pv);
        end
        wait_complete("add_per_cycle_prev");

        // Reset after four accepts, with start and word_valid also high.
        do_start(1'b0);
        for (int i = 0; i < 4; i++) offer(3'(i), 32'hAAAA0000 | 32'(i), '0);
        reset      = 1'b1;
        start      = 1'b1;
        word_valid = 1'b1;
        tick();
        reset      = 1'b0;
        start      = 1'b0;
        word_valid = 1'b0;
        check("midrst_hash",     hash_vector,               '0);
        check("midrst_ready",    VW'(word_ready),           VW'(1'b0));
        check("midrst_complete", VW'(hash_vector_complete), VW'(1'b0));
        check("midrst_order",    VW'(order_error),          VW'(1'b0));

        // word_valid in IDLE changes nothing.
        offer(3'd0, 32'h12345678, '0);
        offer(3'd1, 32'h9abcdef0, '0);
        check("idle_valid_hash",  hash_vector,     '0);
        check("idle_valid_ready", VW'(word_ready), VW'(1'b0));

        exp_v = '0;
        for (int i = 0; i < HL; i++) begin
            d[i] = 32'h01010101 * 32'(i) + 32'h5;
            exp_v[i*WW +: WW] = d[i];
        end
        exp_q.push_back(exp_v);
        do_start(1'b0);
        for (int i = 0; i < HL; i++) offer(3'(i), d[i], '1);
        wait_complete("after_midrst");

`ifdef HASH_ACCUMULATOR_ORDER_CHECK_EN
        // Out-of-order word is dropped and flagged; ready stays high.
        do_start(1'b0);
        offer(3'd3, 32'h77777777, '0);
        check("order_flag",  VW'(order_error), VW'(1'b1));
        check("order_hash",  hash_vector,      '0);
        check("order_ready", VW'(word_ready),  VW'(1'b1));
        exp_v = '0;
        for (int i = 0; i < HL; i++) begin
            d[i] = 32'hC0DE0000 + 32'(i);
            exp_v[i*WW +: WW] = d[i];
        end
        exp_q.push_back(exp_v);
        for (int i = 0; i < HL; i++) offer(3'(i), d[i], '0);
        wait_complete("order_recover");
        check("order_sticky", VW'(order_error), VW'(1'b1));
        do_start(1'b0);
        check("order_cleared_by_start", VW'(order_error), VW'(1'b0));
`else
        // word_index is ignored: words land at the running slot count.
        do_start(1'b0);
        offer(3'd3, 32'h77777777, '0);
        check("noorder_flag",  VW'(order_error), VW'(1'b0));
        check("noorder_slot0", hash_vector,      VW'(32'h77777777));
        exp_v = '0;
        exp_v[31:0] = 32'h77777777;
        for (int i = 1; i < HL; i++) begin
            d[i] = 32'hC0DE0000 + 32'(i);
            exp_v[i*WW +: WW] = d[i];
        end
        exp_q.push_back(exp_v);
        for (int i = 1; i < HL; i++) offer(3'(HL - i), d[i], '0);
        wait_complete("noorder_index_ignored");
        check("noorder_flag_end", VW'(order_error), VW'(1'b0));
`endif

        check("scoreboard_drained", VW'(exp_q.size()), VW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
